// File: rtl/alu_operand_stage.sv
// Decode/operand-fetch stage feeding the RV32I ALU: 32x32 register file, R/I-type decode, valid/ready output slot.
// Optional macro WB_BYPASS_EN: same-cycle writeback data is forwarded into the captured operands.
module alu_operand_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [4:0]  rd,
    output logic        illegal
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned RIDX  = 5;
    localparam logic [6:0]  OP_R  = 7'b0110011;
    localparam logic [6:0]  OP_I  = 7'b0010011;

    logic [XLEN-1:0] regs [NREGS];

    logic [6:0]      opcode;
    logic [RIDX-1:0] rs1;
    logic [RIDX-1:0] rs2;
    logic [2:0]      f3;
    logic            is_r;
    logic            is_i;
    logic            accept;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] b_next;
    logic [6:0]      f7_next;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Field extraction and operand read (async read ports, x0 forced to zero)
    always_comb begin
        opcode  = instr[6:0];
        rs1     = instr[19:15];
        rs2     = instr[24:20];
        f3      = instr[14:12];
        is_r    = (opcode == OP_R);
        is_i    = (opcode == OP_I);
        rs1_val = (rs1 == '0) ? '0 : regs[rs1];
        rs2_val = (rs2 == '0) ? '0 : regs[rs2];
`ifdef WB_BYPASS_EN
        if (wb_en && (wb_rd != '0) && (wb_rd == rs1)) begin
            rs1_val = wb_data;
        end
        if (wb_en && (wb_rd != '0) && (wb_rd == rs2)) begin
            rs2_val = wb_data;
        end
`endif
    end

    // Operand B and function modifier; only shifts keep funct7 on I-type so ADDI never decodes as SUB
    always_comb begin
        b_next  = rs2_val;
        f7_next = instr[31:25];
        if (is_i) begin
            b_next = {{(XLEN-12){instr[31]}}, instr[31:20]};
            if ((f3 != 3'b001) && (f3 != 3'b101)) begin
                f7_next = 7'b0000000;
            end
        end
    end

    // Register file write port; lands on the edge independent of the handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en && (wb_rd != '0)) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // Output slot
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            illegal   <= 1'b0;
            A         <= '0;
            B         <= '0;
            funct3    <= '0;
            funct7    <= '0;
            rd        <= '0;
        end else begin
            illegal <= 1'b0;
            if (accept) begin
                if (is_r || is_i) begin
                    out_valid <= 1'b1;
                    A         <= rs1_val;
                    B         <= b_next;
                    funct3    <= f3;
                    funct7    <= f7_next;
                    rd        <= instr[11:7];
                end else begin
                    out_valid <= 1'b0;
                    illegal   <= 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: per-cycle behavioural model plus directed literal checks.
module tb_alu_operand_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    alu_operand_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
        .A(a), .B(b), .funct3(funct3), .funct7(funct7), .rd(rd), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] addi(input int i);
        return {12'(i), 5'd0, 3'b000, 5'(i + 1), 7'b0010011};
    endfunction

    // Behavioural model: architectural registers plus the one expected output slot
    logic [31:0] m_regs [32];
    logic        m_valid, m_ill;
    logic [31:0] m_a, m_b;
    logic [2:0]  m_f3;
    logic [6:0]  m_f7;
    logic [4:0]  m_rd;

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
        if (wb_en && wb_rd == idx) return wb_data;
`endif
        return m_regs[idx];
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid = 1'b0; m_ill = 1'b0;
            m_a = '0; m_b = '0; m_f3 = '0; m_f7 = '0; m_rd = '0;
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
        end else begin
            m_ill = 1'b0;
            if (in_valid && (!m_valid || out_ready)) begin
                if (instr[6:0] == 7'h33 || instr[6:0] == 7'h13) begin
                    m_valid = 1'b1;
                    m_a  = m_read(instr[19:15]);
                    m_f3 = instr[14:12];
                    m_rd = instr[11:7];
                    if (instr[6:0] == 7'h33) begin
                        m_b  = m_read(instr[24:20]);
                        m_f7 = instr[31:25];
                    end else begin
                        m_b  = 32'($signed(instr[31:20]));
                        m_f7 = (m_f3 == 3'd1 || m_f3 == 3'd5) ? instr[31:25] : 7'd0;
                    end
                end else begin
                    m_valid = 1'b0;
                    m_ill   = 1'b1;
                end
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            if (wb_en && wb_rd != 5'd0) m_regs[wb_rd] = wb_data;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (!reset) begin
            chk("m_in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
            chk("m_out_valid", 32'(out_valid), 32'(m_valid));
            chk("m_illegal", 32'(illegal), 32'(m_ill));
            if (m_valid) begin
                chk("m_A", a, m_a);
                chk("m_B", b, m_b);
                chk("m_funct3", 32'(funct3), 32'(m_f3));
                chk("m_funct7", 32'(funct7), 32'(m_f7));
                chk("m_rd", 32'(rd), 32'(m_rd));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c, idx, consumed;
        logic [4:0] held;
        logic [31:0] exp_a;

        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_A", a, 32'd0);
        chk("rst_B", b, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        cyc();
        reset = 1'b0;

        // x1=5, x2=3, then ADD x3,x1,x2
        wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'd5; cyc();
        wb_rd = 5'd2; wb_data = 32'd3; cyc();
        wb_en = 1'b0;
        in_valid = 1'b1; instr = 32'h002081B3; cyc();
        in_valid = 1'b0;
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_A", a, 32'd5);
        chk("add_B", b, 32'd3);
        chk("add_f3", 32'(funct3), 32'd0);
        chk("add_f7", 32'(funct7), 32'd0);
        chk("add_rd", 32'(rd), 32'd3);
        cyc();
        chk("add_drain", 32'(out_valid), 32'd0);

        // SUB then ADDI back to back
        in_valid = 1'b1; instr = 32'h402081B3; cyc();
        chk("sub_f7", 32'(funct7), 32'h20);
        instr = 32'hFFF08213; cyc();
        chk("addi_B", b, 32'hFFFFFFFF);
        chk("addi_f7", 32'(funct7), 32'd0);
        chk("addi_rd", 32'(rd), 32'd4);

        // SRAI keeps funct7; shamt in B[4:0]
        instr = 32'h4040D293; cyc();
        in_valid = 1'b0;
        chk("srai_B", b, 32'h00000404);
        chk("srai_shamt", 32'(b[4:0]), 32'd4);
        chk("srai_f3", 32'(funct3), 32'd5);
        chk("srai_f7", 32'(funct7), 32'h20);

        // Write to x0 is ignored
        wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'd7; cyc();
        wb_en = 1'b0;
        in_valid = 1'b1; instr = 32'h00000313; cyc();
        in_valid = 1'b0;
        chk("x0_A", a, 32'd0);
        chk("x0_rd", 32'(rd), 32'd6);

        // Same-cycle writeback of x1=9 with accept
        wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'd9;
        in_valid = 1'b1; instr = 32'h002081B3; cyc();
        wb_en = 1'b0; in_valid = 1'b0;
`ifdef WB_BYPASS_EN
        exp_a = 32'd9;
`else
        exp_a = 32'd5;
`endif
        chk("wb_same_cycle_A", a, exp_a);
        chk("wb_same_cycle_B", b, 32'd3);
        cyc();
        in_valid = 1'b1; instr = 32'h002081B3; cyc();
        in_valid = 1'b0;
        chk("wb_next_cycle_A", a, 32'd9);
        cyc();

        // 10-instruction stream with a 3-cycle stall and periodic backpressure
        c = 0; idx = 0; consumed = 0; held = '0;
        while (consumed < 10 && c < 200) begin
            in_valid  = (idx < 10);
            instr     = addi(idx);
            out_ready = !(c >= 1 && c <= 3) && (c % 4 != 3);
            @(negedge clk);
            if (c >= 1 && c <= 3) begin
                chk("hold_in_ready", 32'(in_ready), 32'd0);
                if (c == 1) held = rd;
                else chk("hold_stable_rd", 32'(rd), 32'(held));
            end
            if (out_valid && out_ready) begin
                chk("stream_rd", 32'(rd), 32'(consumed + 1));
                chk("stream_B", b, 32'(consumed));
                consumed++;
            end
            if (in_valid && in_ready) idx++;
            @(posedge clk);
            #1;
            c++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("stream_count", 32'(consumed), 32'd10);
        chk("stream_issued", 32'(idx), 32'd10);
        cyc();

        // Unsupported opcode pulses illegal
        in_valid = 1'b1; instr = 32'h00000003; cyc();
        in_valid = 1'b0;
        chk("load_illegal", 32'(illegal), 32'd1);
        chk("load_valid", 32'(out_valid), 32'd0);
        cyc();
        chk("load_illegal_clear", 32'(illegal), 32'd0);

        // Reset while the slot is full
        out_ready = 1'b0;
        in_valid = 1'b1; instr = 32'h002081B3; cyc();
        in_valid = 1'b0;
        chk("pre_reset_valid", 32'(out_valid), 32'd1);
        reset = 1'b1;
        #1;
        chk("async_reset_valid", 32'(out_valid), 32'd0);
        chk("async_reset_A", a, 32'd0);
        cyc();
        reset = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; instr = 32'h002081B3; cyc();
        in_valid = 1'b0;
        chk("post_reset_A", a, 32'd0);
        chk("post_reset_B", b, 32'd0);
        cyc();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
